// File: rtl/pe_drain_enc.sv
// pe_drain_enc: registered, parametrised priority-drain encoder.
// Accepts a WIDTH-bit request vector over valid/ready and emits the index of
// each set bit as one beat per cycle in priority order; the final beat of a
// vector carries out_last. A zero vector yields a single beat with out_any=0.
//
// Parameters:
//   WIDTH      request vector width (>=2)
//   LSB_FIRST  0: highest set index first, 1: lowest set index first
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready/in_req   request vector handshake (in_ready combinational)
//   out_valid/out_ready        beat handshake
//   out_idx, out_onehot        encoded / one-hot index of the current beat
//   out_any                    beat carries a real request
//   out_last                   final beat of the current vector
//   out_cnt                    popcount of the accepted vector (PE_COUNT_EN only)
// Configuration macro: PE_COUNT_EN adds the out_cnt port and popcount logic.
module pe_drain_enc #(
  parameter int unsigned WIDTH     = 16,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_req,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(WIDTH)-1:0] out_idx,
  output logic [WIDTH-1:0]         out_onehot,
  output logic                     out_any,
  output logic                     out_last
`ifdef PE_COUNT_EN
  ,
  output logic [$clog2(WIDTH):0]   out_cnt
`endif
);

  localparam int unsigned IDXW = $clog2(WIDTH);
  localparam int unsigned CNTW = IDXW + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  pending;

  logic              accept;
  logic              advance;
  logic [WIDTH-1:0]  src;
  logic [IDXW-1:0]   sel_idx;
  logic              sel_any;
  logic [WIDTH-1:0]  sel_onehot;
  logic [WIDTH-1:0]  remain;

  // A new vector may enter whenever no beat is held or the held beat is
  // the last one and is being consumed this cycle.
  assign in_ready = (state == IDLE) || (out_ready && out_last);
  assign accept   = in_valid && in_ready;
  assign advance  = (state == DRAIN) && out_ready && !out_last;

  // A freshly accepted vector takes precedence over the (then empty) residue.
  assign src = accept ? in_req : pending;

  // Single-cycle priority select: in ascending order, MSB-first keeps the last
  // hit, LSB-first keeps the first hit.
  always_comb begin
    sel_idx = '0;
    sel_any = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (src[i]) begin
        if (!LSB_FIRST || !sel_any) sel_idx = IDXW'(i);
        sel_any = 1'b1;
      end
    end
  end

  assign sel_onehot = sel_any ? (WIDTH'(1) << sel_idx) : '0;
  assign remain     = src & ~sel_onehot;

`ifdef PE_COUNT_EN
  logic [CNTW-1:0] pop;

  // Popcount of the incoming vector, captured only on accept.
  always_comb begin
    pop = '0;
    for (int i = 0; i < int'(WIDTH); i++) pop = pop + CNTW'(in_req[i]);
  end
`endif

  // State, residue and registered beat outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pending    <= '0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
      out_any    <= 1'b0;
      out_last   <= 1'b0;
`ifdef PE_COUNT_EN
      out_cnt    <= '0;
`endif
    end else if (accept || advance) begin
      state      <= DRAIN;
      pending    <= remain;
      out_valid  <= 1'b1;
      out_idx    <= sel_idx;
      out_onehot <= sel_onehot;
      out_any    <= sel_any;
      out_last   <= ~|remain;
`ifdef PE_COUNT_EN
      if (accept) out_cnt <= pop;
`endif
    end else if ((state == DRAIN) && out_ready) begin
      // Last beat consumed with nothing new behind it.
      state     <= IDLE;
      out_valid <= 1'b0;
    end
  end

endmodule
